// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: state encoding,
// boolean constants and the per-state control decode.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        FREEZE  = 2'd3
    } ctrlState_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic pcWrEn;
        logic ifidWrEn;
        logic ifidFlush;
        logic idexBubble;
        logic exmemWrEn;
    } ctrlBits_t;

    // Moore decode of the pipeline control lines for one state
    function automatic ctrlBits_t decodeState(input ctrlState_t s);
        ctrlBits_t c;
        case (s)
            RUN:     c = '{TRUE,  TRUE,  FALSE, FALSE, TRUE };
            LDSTALL: c = '{FALSE, FALSE, FALSE, TRUE,  TRUE };
            FLUSH:   c = '{TRUE,  TRUE,  TRUE,  TRUE,  TRUE };
            default: c = '{FALSE, FALSE, FALSE, FALSE, FALSE};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// 32-bit (by default) saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: turns registered branch / load-use hazard
// requests and the data-memory wait into stall, bubble and flush controls.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is
// defined; otherwise stallCount and flushCount read as zero.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cHazard,
    input  logic        dHazard,
    input  logic        memWait,
    output logic        pcWrEn,
    output logic        ifidWrEn,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic        exmemWrEn,
    output logic [1:0]  ctrlState,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    // Count holds the number of extra cycles left after the current one,
    // so a fresh operation loads CYCLES-1.
    localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FLUSH_LOAD = 2'(BRANCH_FLUSH_CYCLES - 1);

    ctrlState_t state, stateNext;
    ctrlState_t retState, retStateNext;
    logic [1:0] count, countNext;
    ctrlBits_t  ctrl;

    // State, remaining-cycle count and the state to resume after a freeze
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            retState <= RUN;
            count    <= 2'd0;
        end else begin
            state    <= stateNext;
            retState <= retStateNext;
            count    <= countNext;
        end
    end

    // Next-state rules: memory wait beats branch, branch beats load-use
    always_comb begin
        stateNext    = state;
        retStateNext = retState;
        countNext    = count;
        if (memWait) begin
            stateNext = FREEZE;
            if (state != FREEZE) begin
                retStateNext = state;
            end
        end else begin
            case (state)
                RUN: begin
                    if (cHazard) begin
                        stateNext = FLUSH;
                        countNext = FLUSH_LOAD;
                    end else if (dHazard) begin
                        stateNext = LDSTALL;
                        countNext = STALL_LOAD;
                    end
                end
                LDSTALL, FLUSH: begin
                    if (cHazard) begin
                        stateNext = FLUSH;
                        countNext = FLUSH_LOAD;
                    end else if (count == 2'd0) begin
                        stateNext = RUN;
                    end else begin
                        countNext = count - 2'd1;
                    end
                end
                FREEZE: begin
                    stateNext = retState;
                end
                default: begin
                    stateNext = RUN;
                    countNext = 2'd0;
                end
            endcase
        end
    end

    // Moore controls, overridden to the frozen pattern while memory waits
    always_comb begin
        ctrl = decodeState(state);
        if (memWait && rst) begin
            ctrl = decodeState(FREEZE);
        end
    end

    assign pcWrEn     = ctrl.pcWrEn;
    assign ifidWrEn   = ctrl.ifidWrEn;
    assign ifidFlush  = ctrl.ifidFlush;
    assign idexBubble = ctrl.idexBubble;
    assign exmemWrEn  = ctrl.exmemWrEn;
    assign ctrlState  = state;

`ifdef PIPELINE_CTRL_PERF_EN
    sat_counter #(.WIDTH(32)) stallCounter (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == LDSTALL) || (state == FREEZE)),
        .count (stallCount)
    );

    sat_counter #(.WIDTH(32)) flushCounter (
        .clk   (clk),
        .rst   (rst),
        .en    (state == FLUSH),
        .count (flushCount)
    );
`else
    assign stallCount = 32'd0;
    assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus a
// randomized run checked against a cycle-count model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int LSC = 3;
    localparam int BFC = 2;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cHazard = 1'b0;
    logic        dHazard = 1'b0;
    logic        memWait = 1'b0;
    logic        pcWrEn, ifidWrEn, ifidFlush, idexBubble, exmemWrEn;
    logic [1:0]  ctrlState;
    logic [31:0] stallCount, flushCount;
    logic [4:0]  dutCtrl;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of stall/flush still owed, plus a freeze flag
    int  stallLeft = 0;
    int  flushLeft = 0;
    bit  frozen = 1'b0;
    int  mStall = 0;
    int  mFlush = 0;

    pipeline_ctrl #(
        .LOAD_STALL_CYCLES   (LSC),
        .BRANCH_FLUSH_CYCLES (BFC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cHazard    (cHazard),
        .dHazard    (dHazard),
        .memWait    (memWait),
        .pcWrEn     (pcWrEn),
        .ifidWrEn   (ifidWrEn),
        .ifidFlush  (ifidFlush),
        .idexBubble (idexBubble),
        .exmemWrEn  (exmemWrEn),
        .ctrlState  (ctrlState),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    assign dutCtrl = {pcWrEn, ifidWrEn, ifidFlush, idexBubble, exmemWrEn};

    always #5 clk = ~clk;

    function automatic int modelState();
        if (frozen)        return 3;
        if (flushLeft > 0) return 2;
        if (stallLeft > 0) return 1;
        return 0;
    endfunction

    // Expected {pcWrEn, ifidWrEn, ifidFlush, idexBubble, exmemWrEn}
    function automatic logic [4:0] expCtrl(input int st, input logic m);
        if (m) return 5'b00000;
        case (st)
            0:       return 5'b11001;
            1:       return 5'b00011;
            2:       return 5'b11111;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic modelReset();
        stallLeft = 0;
        flushLeft = 0;
        frozen    = 1'b0;
        mStall    = 0;
        mFlush    = 0;
    endtask

    task automatic modelStep(input logic c, input logic d, input logic m);
        int st;
        st = modelState();
        if (st == 1 || st == 3) mStall++;
        if (st == 2) mFlush++;
        if (m) begin
            frozen = 1'b1;
        end else if (frozen) begin
            frozen = 1'b0;
        end else if (flushLeft > 0) begin
            flushLeft--;
            if (c) flushLeft = BFC;
        end else if (stallLeft > 0) begin
            stallLeft--;
            if (c) begin
                stallLeft = 0;
                flushLeft = BFC;
            end
        end else if (c) begin
            flushLeft = BFC;
        end else if (d) begin
            stallLeft = LSC;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) modelStep(cHazard, dHazard, memWait);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic d, input logic m);
        cHazard = c;
        dHazard = d;
        memWait = m;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        #12;
        checks++;
        if (ctrlState !== 2'd0 || dutCtrl !== 5'b11001) begin
            errors++;
            $display("[TB] FAIL reset_values: state=%0d ctrl=%b, expected state=0 ctrl=11001", ctrlState, dutCtrl);
        end
        checks++;
        if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: stall=%0d flush=%0d, expected 0 0", stallCount, flushCount);
        end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_load_stall();
        int expS[5] = '{0, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i == 0), 1'b0);
            #1;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], 1'b0)) begin
                errors++;
                $display("[TB] FAIL load_stall cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], 1'b0));
            end
            tick();
        end
    endtask

    task automatic test_abort_stall();
        int expS[6] = '{0, 1, 1, 2, 2, 0};
        logic [31:0] s0, f0;
        s0 = stallCount;
        f0 = flushCount;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i == 2), (i == 0), 1'b0);
            #1;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], 1'b0)) begin
                errors++;
                $display("[TB] FAIL abort_stall cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], 1'b0));
            end
            tick();
        end
        checks++;
        if (stallCount - s0 !== (PERF ? 32'd2 : 32'd0) || flushCount - f0 !== (PERF ? 32'd2 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL abort_stall_counts: stall+%0d flush+%0d, expected stall+%0d flush+%0d", stallCount - s0, flushCount - f0, PERF ? 2 : 0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_simultaneous();
        int expS[4] = '{0, 2, 2, 0};
        logic [31:0] s0, f0;
        s0 = stallCount;
        f0 = flushCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i == 0), (i == 0), 1'b0);
            #1;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], 1'b0)) begin
                errors++;
                $display("[TB] FAIL simultaneous cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], 1'b0));
            end
            tick();
        end
        checks++;
        if (stallCount - s0 !== 32'd0 || flushCount - f0 !== (PERF ? 32'd2 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL simultaneous_counts: stall+%0d flush+%0d, expected stall+0 flush+%0d", stallCount - s0, flushCount - f0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_extend_flush();
        int expS[5] = '{0, 2, 2, 2, 0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i < 2), (i == 2), 1'b0);
            #1;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], 1'b0)) begin
                errors++;
                $display("[TB] FAIL extend_flush cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], 1'b0));
            end
            tick();
        end
    endtask

    task automatic test_freeze_stall();
        int   expS[9] = '{0, 1, 1, 1, 3, 3, 3, 1, 0};
        logic mSeq[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        int   frozenCycles = 0;
        logic [31:0] s0;
        s0 = stallCount;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, (i == 0), mSeq[i]);
            #1;
            if (exmemWrEn === 1'b0) frozenCycles++;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], mSeq[i])) begin
                errors++;
                $display("[TB] FAIL freeze_stall cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], mSeq[i]));
            end
            tick();
        end
        checks++;
        if (frozenCycles != 4) begin
            errors++;
            $display("[TB] FAIL freeze_window: exmemWrEn low %0d cycles, expected 4", frozenCycles);
        end
        checks++;
        if (stallCount - s0 !== (PERF ? 32'd7 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL freeze_stall_count: stall+%0d, expected stall+%0d", stallCount - s0, PERF ? 7 : 0);
        end
    endtask

    task automatic test_freeze_priority();
        int   expS[3] = '{0, 3, 0};
        logic mSeq[3] = '{1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 0), (i == 0), mSeq[i]);
            #1;
            checks++;
            if (ctrlState !== 2'(expS[i]) || dutCtrl !== expCtrl(expS[i], mSeq[i])) begin
                errors++;
                $display("[TB] FAIL freeze_priority cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, expS[i], expCtrl(expS[i], mSeq[i]));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_flush();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctrlState !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reset_flush_entry: state=%0d, expected 2", ctrlState);
        end
        #1 rst = 1'b0;
        modelReset();
        #1;
        checks++;
        if (ctrlState !== 2'd0 || dutCtrl !== 5'b11001 || stallCount !== 32'd0 || flushCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_flush: state=%0d ctrl=%b stall=%0d flush=%0d, expected 0 11001 0 0", ctrlState, dutCtrl, stallCount, flushCount);
        end
        #1 rst = 1'b1;
        tick();
        checks++;
        if (ctrlState !== 2'd0 || dutCtrl !== 5'b11001) begin
            errors++;
            $display("[TB] FAIL reset_no_residue: state=%0d ctrl=%b, expected 0 11001", ctrlState, dutCtrl);
        end
    endtask

    task automatic test_random();
        logic [31:0] expStall, expFlush;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            #1;
            expStall = PERF ? 32'(mStall) : 32'd0;
            expFlush = PERF ? 32'(mFlush) : 32'd0;
            checks++;
            if (ctrlState !== 2'(modelState()) || dutCtrl !== expCtrl(modelState(), memWait)) begin
                errors++;
                $display("[TB] FAIL random_ctrl cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, ctrlState, dutCtrl, modelState(), expCtrl(modelState(), memWait));
            end
            checks++;
            if (stallCount !== expStall || flushCount !== expFlush) begin
                errors++;
                $display("[TB] FAIL random_counters cycle %0d: stall=%0d flush=%0d, expected %0d %0d", i, stallCount, flushCount, expStall, expFlush);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_abort_stall();
        test_simultaneous();
        test_extend_flush();
        test_freeze_stall();
        test_freeze_priority();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1: bubble cycles inserted per load-use hazard, legal range 1..3.
REQ-002 Parameter BRANCH_FLUSH_CYCLES, default 1: flush cycles per taken branch, legal range 1..2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cHazard  input  1  control-hazard request (taken branch), registered upstream.
REQ-006 dHazard  input  1  data-hazard request (load-use), registered upstream.
REQ-007 memWait  input  1  data memory not ready; freeze whole pipeline.
REQ-008 pcWrEn  output  1  PC register write enable.
REQ-009 ifidWrEn  output  1  IF/ID register write enable.
REQ-010 ifidFlush  output  1  clear IF/ID to NOP.
REQ-011 idexBubble  output  1  load NOP into ID/EX.
REQ-012 exmemWrEn  output  1  EX/MEM and MEM/WB write enable.
REQ-013 ctrlState  output  2  current FSM state, for debug.
REQ-014 stallCount, flushCount  output  32 each  performance counters (see Configuration).

Function
REQ-015 FSM states SHALL be RUN, LDSTALL, FLUSH, FREEZE; state and cycle counter are registers; all outputs except the memWait override are Moore decodes of state.
REQ-016 RUN: pcWrEn=1, ifidWrEn=1, ifidFlush=0, idexBubble=0, exmemWrEn=1.
REQ-017 LDSTALL: pcWrEn=0, ifidWrEn=0, ifidFlush=0, idexBubble=1, exmemWrEn=1.
REQ-018 FLUSH: pcWrEn=1, ifidWrEn=1, ifidFlush=1, idexBubble=1, exmemWrEn=1.
REQ-019 FREEZE: pcWrEn=0, ifidWrEn=0, ifidFlush=0, idexBubble=0, exmemWrEn=0.
REQ-020 memWait=1 in any state SHALL combinationally force all five enables/controls to the FREEZE values in the same cycle, and next state SHALL be FREEZE.
REQ-021 In FREEZE the state SHALL hold the return state and remaining count; when memWait falls, next state SHALL be the held return state with count unchanged.
REQ-022 From RUN, sampled cHazard=1 SHALL enter FLUSH with count=BRANCH_FLUSH_CYCLES-1; else dHazard=1 SHALL enter LDSTALL with count=LOAD_STALL_CYCLES-1; else stay RUN.
REQ-023 Priority SHALL be memWait > cHazard > dHazard; simultaneous cHazard and dHazard SHALL yield FLUSH only.
REQ-024 cHazard=1 while in LDSTALL SHALL abort the stall and enter FLUSH with a freshly loaded count.
REQ-025 cHazard=1 while in FLUSH SHALL reload the count (extend flush); dHazard in FLUSH SHALL be ignored.
REQ-026 LDSTALL/FLUSH with count=0 and no new request SHALL return to RUN next cycle; otherwise count decrements by 1.
REQ-027 Latency: a request sampled at edge N SHALL produce its controls in cycle N+1, lasting exactly the configured cycle count absent interruption.

Reset
REQ-028 rst=0 SHALL immediately set state RUN, count 0, counters 0; outputs take RUN values during and after reset.
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard the operation; no residual bubble after release.

Configuration
REQ-030 Macro PIPELINE_CTRL_PERF_EN defined: stallCount SHALL increment each cycle in LDSTALL or FREEZE, flushCount each cycle in FLUSH; both saturate at 0xFFFFFFFF.
REQ-031 Macro undefined: counters SHALL not be instantiated and stallCount, flushCount SHALL be tied to 0.

Structure
REQ-032 State encoding typedef (RUN=0, LDSTALL=1, FLUSH=2, FREEZE=3) and the TRUE/FALSE constants SHALL live in the shared Types.v package.
REQ-033 One sub-module, sat_counter (32-bit saturating incrementer with enable, async active-low reset), instantiated twice under the macro.

Verification
REQ-034 Defaults, dHazard pulse 1 cycle -> one cycle LDSTALL (pcWrEn=0, idexBubble=1), then RUN.
REQ-035 LOAD_STALL_CYCLES=3, dHazard pulse, cHazard at 2nd stall cycle -> LDSTALL x2, FLUSH x1, RUN.
REQ-036 cHazard and dHazard same cycle -> FLUSH only, zero LDSTALL cycles, flushCount=1.
REQ-037 memWait high 4 cycles during LDSTALL (LOAD_STALL_CYCLES=2) -> exmemWrEn=0 for 4 cycles, then remaining stall cycle, then RUN; stallCount=6.
REQ-038 rst low mid-FLUSH -> RUN values same cycle, ctrlState=0, counters 0.
REQ-039 Macro undefined, 100 random hazards -> stallCount=flushCount=0 throughout.
